// File: rtl/reveal_ctrl.sv
// reveal_ctrl: reveal/flag game engine behind board; a nonzero reveal is busy 3 cycles, each flooded cell adds 3 (+8 if zero).
// Commands are dropped, never queued, unless IDLE + PLAY + board_ready; flood stack/NBR exist only with REVEAL_FLOOD_EN.
module reveal_ctrl #(
   parameter int x_size       = 16,
   parameter int y_size       = 16,
   parameter int x_coord_bits = 4,
   parameter int y_coord_bits = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               board_ready,
   input  logic [4:0]                         cell_val,
   input  logic [x_coord_bits+y_coord_bits:0] num_non_mines,
   input  logic [x_coord_bits-1:0]            cursor_x,
   input  logic [y_coord_bits-1:0]            cursor_y,
   input  logic                               btn_reveal,
   input  logic                               btn_flag,
   output logic [x_coord_bits-1:0]            board_x,
   output logic [y_coord_bits-1:0]            board_y,
   input  logic [x_coord_bits-1:0]            q_x,
   input  logic [y_coord_bits-1:0]            q_y,
   output logic [1:0]                         q_state,
   output logic [1:0]                         game_state,
   output logic                               busy,
   output logic [x_coord_bits+y_coord_bits:0] revealed_count,
   output logic [x_coord_bits+y_coord_bits:0] flag_count
);
   localparam int XB    = x_coord_bits;
   localparam int YB    = y_coord_bits;
   localparam int N     = XB + YB + 1;
   localparam int CELLS = x_size * y_size;
   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [1:0] C_HIDDEN   = 2'b00;
   localparam logic [1:0] C_REVEALED = 2'b01;
   localparam logic [1:0] C_FLAGGED  = 2'b10;

   localparam logic [1:0] G_PLAY = 2'b00;
   localparam logic [1:0] G_WON  = 2'b01;
   localparam logic [1:0] G_LOST = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_EVAL = 3'd2,
`ifdef REVEAL_FLOOD_EN
      ST_NBR  = 3'd4,
`endif
      ST_POP  = 3'd3
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cells_q [CELLS];
   logic [1:0]        cells_d [CELLS];
   logic [XB-1:0]     board_x_q, board_x_d;
   logic [YB-1:0]     board_y_q, board_y_d;
   logic [1:0]        q_state_q, q_state_d;
   logic [N-1:0]      rev_cnt_q, rev_cnt_d;
   logic [N-1:0]      flag_cnt_q, flag_cnt_d;
   logic [1:0]        game_q, game_d;
   logic              cmd_ok;
   logic [IDX_W-1:0]  cur_idx;
   logic [1:0]        cur_cell;

`ifdef REVEAL_FLOOD_EN
   logic [2:0]        nbr_q, nbr_d;
   logic [IDX_W-1:0]  sp_q, sp_d;
   logic [XB-1:0]     stk_x_q [CELLS];
   logic [XB-1:0]     stk_x_d [CELLS];
   logic [YB-1:0]     stk_y_q [CELLS];
   logic [YB-1:0]     stk_y_d [CELLS];
   int                nbr_dx, nbr_dy, nbr_xi, nbr_yi;
   logic              nbr_in;
   logic [IDX_W-1:0]  nbr_idx;
`endif

   function automatic logic [IDX_W-1:0] cell_idx(input logic [XB-1:0] x, input logic [YB-1:0] y);
      return IDX_W'(int'(y) * x_size + int'(x));
   endfunction

   assign cmd_ok = (state_q == ST_IDLE) && (game_q == G_PLAY) && board_ready;

   always_comb begin
      state_d    = state_q;
      cells_d    = cells_q;
      board_x_d  = board_x_q;
      board_y_d  = board_y_q;
      rev_cnt_d  = rev_cnt_q;
      flag_cnt_d = flag_cnt_q;
      game_d     = game_q;
      cur_idx    = cell_idx(cursor_x, cursor_y);
      cur_cell   = cells_q[cur_idx];
`ifdef REVEAL_FLOOD_EN
      nbr_d      = nbr_q;
      sp_d       = sp_q;
      stk_x_d    = stk_x_q;
      stk_y_d    = stk_y_q;
      nbr_dx     = 0;
      nbr_dy     = 0;
      nbr_xi     = 0;
      nbr_yi     = 0;
      nbr_in     = 1'b0;
      nbr_idx    = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            // Reveal has priority; a simultaneous flag is discarded.
            if (cmd_ok && btn_reveal) begin
               if (cur_cell == C_HIDDEN) begin
                  cells_d[cur_idx] = C_REVEALED;
                  rev_cnt_d        = rev_cnt_q + N'(1);
                  board_x_d        = cursor_x;
                  board_y_d        = cursor_y;
                  state_d          = ST_WAIT;
               end
            end else if (cmd_ok && btn_flag) begin
               if (cur_cell == C_HIDDEN) begin
                  cells_d[cur_idx] = C_FLAGGED;
                  flag_cnt_d       = flag_cnt_q + N'(1);
               end else if (cur_cell == C_FLAGGED) begin
                  cells_d[cur_idx] = C_HIDDEN;
                  flag_cnt_d       = flag_cnt_q - N'(1);
               end
            end
         end
         ST_WAIT: state_d = ST_EVAL;
         ST_EVAL: begin
            if (cell_val[4]) begin
               game_d  = G_LOST;
               state_d = ST_IDLE;
            end else if (cell_val != 5'd0) begin
               state_d = ST_POP;
            end else begin
`ifdef REVEAL_FLOOD_EN
               nbr_d   = 3'd0;
               state_d = ST_NBR;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef REVEAL_FLOOD_EN
         ST_NBR: begin
            case (nbr_q)
               3'd0:    begin nbr_dx =  0; nbr_dy = -1; end
               3'd1:    begin nbr_dx =  0; nbr_dy =  1; end
               3'd2:    begin nbr_dx = -1; nbr_dy =  0; end
               3'd3:    begin nbr_dx =  1; nbr_dy =  0; end
               3'd4:    begin nbr_dx = -1; nbr_dy = -1; end
               3'd5:    begin nbr_dx =  1; nbr_dy = -1; end
               3'd6:    begin nbr_dx = -1; nbr_dy =  1; end
               default: begin nbr_dx =  1; nbr_dy =  1; end
            endcase
            // Signed integer compares so edge cells never wrap to the far side.
            nbr_xi = int'(board_x_q) + nbr_dx;
            nbr_yi = int'(board_y_q) + nbr_dy;
            nbr_in = (nbr_xi >= 0) && (nbr_xi < x_size) && (nbr_yi >= 0) && (nbr_yi < y_size);
            if (nbr_in) begin
               nbr_idx = cell_idx(XB'(nbr_xi), YB'(nbr_yi));
               if (cells_q[nbr_idx] == C_HIDDEN) begin
                  cells_d[nbr_idx] = C_REVEALED;
                  rev_cnt_d        = rev_cnt_q + N'(1);
                  stk_x_d[sp_q]    = XB'(nbr_xi);
                  stk_y_d[sp_q]    = YB'(nbr_yi);
                  sp_d             = sp_q + IDX_W'(1);
               end
            end
            nbr_d = nbr_q + 3'd1;
            if (nbr_q == 3'd7) state_d = ST_POP;
         end
`endif
         ST_POP: begin
`ifdef REVEAL_FLOOD_EN
            if (sp_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               sp_d      = sp_q - IDX_W'(1);
               board_x_d = stk_x_q[sp_q - IDX_W'(1)];
               board_y_d = stk_y_q[sp_q - IDX_W'(1)];
               state_d   = ST_WAIT;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_IDLE) && (state_q != ST_IDLE) && (game_d == G_PLAY) &&
          (rev_cnt_d == num_non_mines))
         game_d = G_WON;

      q_state_d = cells_d[cell_idx(q_x, q_y)];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         for (int i = 0; i < CELLS; i++) cells_q[i] <= C_HIDDEN;
         board_x_q  <= '0;
         board_y_q  <= '0;
         q_state_q  <= C_HIDDEN;
         rev_cnt_q  <= '0;
         flag_cnt_q <= '0;
         game_q     <= G_PLAY;
      end else begin
         state_q    <= state_d;
         cells_q    <= cells_d;
         board_x_q  <= board_x_d;
         board_y_q  <= board_y_d;
         q_state_q  <= q_state_d;
         rev_cnt_q  <= rev_cnt_d;
         flag_cnt_q <= flag_cnt_d;
         game_q     <= game_d;
      end
   end

`ifdef REVEAL_FLOOD_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nbr_q <= '0;
         sp_q  <= '0;
         for (int i = 0; i < CELLS; i++) begin
            stk_x_q[i] <= '0;
            stk_y_q[i] <= '0;
         end
      end else begin
         nbr_q   <= nbr_d;
         sp_q    <= sp_d;
         stk_x_q <= stk_x_d;
         stk_y_q <= stk_y_d;
      end
   end
`endif

   assign board_x        = board_x_q;
   assign board_y        = board_y_q;
   assign q_state        = q_state_q;
   assign game_state     = game_q;
   assign busy           = (state_q != ST_IDLE);
   assign revealed_count = rev_cnt_q;
   assign flag_count     = flag_cnt_q;

endmodule

// File: tb/tb_reveal_ctrl.sv
// Directed bench for reveal_ctrl on a 4x4 board with a 1-cycle registered board model.
module tb_reveal_ctrl;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         board_ready;
   logic [4:0]   cell_val;
   logic [N-1:0] num_non_mines;
   logic [1:0]   cursor_x, cursor_y;
   logic         btn_reveal, btn_flag;
   logic [1:0]   board_x, board_y;
   logic [1:0]   q_x, q_y;
   logic [1:0]   q_state;
   logic [1:0]   game_state;
   logic         busy;
   logic [N-1:0] revealed_count, flag_count;

   logic [4:0]   layout [16];
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   reveal_ctrl #(
      .x_size(4), .y_size(4), .x_coord_bits(2), .y_coord_bits(2)
   ) dut (
      .clk(clk), .reset(reset), .board_ready(board_ready), .cell_val(cell_val),
      .num_non_mines(num_non_mines), .cursor_x(cursor_x), .cursor_y(cursor_y),
      .btn_reveal(btn_reveal), .btn_flag(btn_flag), .board_x(board_x), .board_y(board_y),
      .q_x(q_x), .q_y(q_y), .q_state(q_state), .game_state(game_state), .busy(busy),
      .revealed_count(revealed_count), .flag_count(flag_count)
   );

   // board: registered read, one cycle after the address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cell_val <= '0;
      else       cell_val <= layout[{board_y, board_x}];
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      tick;
   endtask

   task automatic pulse(input logic r, input logic f, input logic [1:0] x, input logic [1:0] y);
      cursor_x   = x;
      cursor_y   = y;
      btn_reveal = r;
      btn_flag   = f;
      tick;
      btn_reveal = 1'b0;
      btn_flag   = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 2000) begin
         n++;
         tick;
      end
      chk("idle_reached", 32'(busy), 0);
   endtask

   task automatic get_q(input logic [1:0] x, input logic [1:0] y, output logic [1:0] s);
      q_x = x;
      q_y = y;
      tick;
      s = q_state;
   endtask

   // single mine at (3,3); its three neighbours read 1, everything else 0
   task automatic mine33;
      for (int i = 0; i < 16; i++) layout[i] = 5'd0;
      layout[15] = 5'h10;
      layout[10] = 5'd1;
      layout[11] = 5'd1;
      layout[14] = 5'd1;
   endtask

   initial begin
      int         n;
      logic [1:0] s;

      reset         = 1'b1;
      board_ready   = 1'b1;
      btn_reveal    = 1'b0;
      btn_flag      = 1'b0;
      cursor_x      = 2'd0;
      cursor_y      = 2'd0;
      q_x           = 2'd0;
      q_y           = 2'd0;
      num_non_mines = 5'd15;
      mine33();
      tick;
      tick;
      reset = 1'b0;
      tick;

      chk("rst_board_x", 32'(board_x), 0);
      chk("rst_board_y", 32'(board_y), 0);
      chk("rst_q_state", 32'(q_state), 0);
      chk("rst_revealed", 32'(revealed_count), 0);
      chk("rst_flags", 32'(flag_count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_game", 32'(game_state), 0);

      // nonzero single reveal
      layout[5] = 5'd2;
      pulse(1'b1, 1'b0, 2'd1, 2'd1);
      wait_idle(n);
      chk("single_busy_cycles", n, 3);
      chk("single_board_x", 32'(board_x), 1);
      chk("single_board_y", 32'(board_y), 1);
      get_q(2'd1, 2'd1, s);
      chk("single_q_state", 32'(s), 1);
      chk("single_revealed", 32'(revealed_count), 1);
      chk("single_game", 32'(game_state), 0);

      // mine reveal, then commands are frozen out
      pulse(1'b1, 1'b0, 2'd3, 2'd3);
      wait_idle(n);
      chk("mine_busy_cycles", n, 2);
      chk("mine_game", 32'(game_state), 2);
      chk("mine_revealed", 32'(revealed_count), 2);
      pulse(1'b1, 1'b0, 2'd0, 2'd0);
      chk("lost_reveal_busy", 32'(busy), 0);
      pulse(1'b0, 1'b1, 2'd0, 2'd0);
      chk("lost_flags", 32'(flag_count), 0);
      chk("lost_revealed", 32'(revealed_count), 2);
      get_q(2'd0, 2'd0, s);
      chk("lost_q00", 32'(s), 0);
      chk("lost_game_sticky", 32'(game_state), 2);

      // flood from (0,0)
      do_reset();
      mine33();
      pulse(1'b1, 1'b0, 2'd0, 2'd0);
      wait_idle(n);
`ifdef REVEAL_FLOOD_EN
      chk("flood_busy_cycles", n, 141);
      chk("flood_revealed", 32'(revealed_count), 15);
      chk("flood_game", 32'(game_state), 1);
      get_q(2'd2, 2'd2, s);
      chk("flood_q22", 32'(s), 1);
`else
      chk("noflood_busy_cycles", n, 2);
      chk("noflood_revealed", 32'(revealed_count), 1);
      chk("noflood_game", 32'(game_state), 0);
      get_q(2'd1, 2'd0, s);
      chk("noflood_q10", 32'(s), 0);
`endif
      get_q(2'd3, 2'd3, s);
      chk("flood_q33_hidden", 32'(s), 0);

      // flag / reveal-on-flag / unflag
      do_reset();
      pulse(1'b0, 1'b1, 2'd2, 2'd0);
      chk("flag1_count", 32'(flag_count), 1);
      get_q(2'd2, 2'd0, s);
      chk("flag1_q", 32'(s), 2);
      pulse(1'b1, 1'b0, 2'd2, 2'd0);
      chk("flagrev_busy", 32'(busy), 0);
      chk("flagrev_count", 32'(flag_count), 1);
      chk("flagrev_revealed", 32'(revealed_count), 0);
      get_q(2'd2, 2'd0, s);
      chk("flagrev_q", 32'(s), 2);
      pulse(1'b0, 1'b1, 2'd2, 2'd0);
      chk("unflag_count", 32'(flag_count), 0);
      get_q(2'd2, 2'd0, s);
      chk("unflag_q", 32'(s), 0);

      // simultaneous reveal and flag
      do_reset();
      pulse(1'b1, 1'b1, 2'd1, 2'd0);
      wait_idle(n);
      get_q(2'd1, 2'd0, s);
      chk("both_q", 32'(s), 1);
      chk("both_flags", 32'(flag_count), 0);
`ifdef REVEAL_FLOOD_EN
      chk("both_revealed", 32'(revealed_count), 15);
`else
      chk("both_revealed", 32'(revealed_count), 1);
`endif

      // reset in the middle of a flood
      do_reset();
      q_x = 2'd1;
      q_y = 2'd0;
      pulse(1'b1, 1'b0, 2'd1, 2'd0);
      tick;
      tick;
`ifdef REVEAL_FLOOD_EN
      chk("mid_flood_busy", 32'(busy), 1);
`else
      chk("mid_flood_busy", 32'(busy), 0);
`endif
      chk("mid_flood_q", 32'(q_state), 1);
      reset = 1'b1;
      tick;
      chk("midrst_board_x", 32'(board_x), 0);
      chk("midrst_board_y", 32'(board_y), 0);
      chk("midrst_q_state", 32'(q_state), 0);
      chk("midrst_revealed", 32'(revealed_count), 0);
      chk("midrst_flags", 32'(flag_count), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_game", 32'(game_state), 0);
      reset = 1'b0;
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) begin
            get_q(2'(x), 2'(y), s);
            chk($sformatf("midrst_q_%0d_%0d", x, y), 32'(s), 0);
         end
      end

      // board not ready
      board_ready = 1'b0;
      pulse(1'b1, 1'b0, 2'd0, 2'd0);
      chk("notready_busy", 32'(busy), 0);
      tick;
      chk("notready_busy2", 32'(busy), 0);
      chk("notready_revealed", 32'(revealed_count), 0);
      get_q(2'd0, 2'd0, s);
      chk("notready_q", 32'(s), 0);
      board_ready = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
